// File: rtl/bcd_to_bin_if.sv
// Handshake and data bundle between a BCD source and the bcd_to_bin converter.
// The source drives the start strobe and the three digits, and the converter returns status and the binary result.
interface bcd_to_bin_if #(
   parameter int N = 8
);
   logic         start;
   logic [3:0]   hundreds;
   logic [3:0]   tens;
   logic [3:0]   ones;
   logic         busy;
   logic         done;
   logic [N-1:0] value;
   logic         err_digit;
   logic         err_ovf;

   modport master (
      output start, hundreds, tens, ones,
      input  busy, done, value, err_digit, err_ovf
   );

   modport slave (
      input  start, hundreds, tens, ones,
      output busy, done, value, err_digit, err_ovf
   );
endinterface

// File: rtl/bcd_to_bin.sv
// Sequential three-digit BCD to N-bit binary converter: checks the digits, then folds one digit per clock
// as acc*10+digit. Non-decimal digits and results above 2^N-1 are flagged, and an out-of-range result saturates.
module bcd_to_bin #(
   parameter int N = 8
) (
   input  logic        clk_50mhz,
   input  logic        rst_n,
   bcd_to_bin_if.slave bus
);
   localparam logic [1:0]  S_IDLE  = 2'd0;
   localparam logic [1:0]  S_CHECK = 2'd1;
   localparam logic [1:0]  S_ACC   = 2'd2;
   localparam logic [16:0] MAX_VAL = (17'd1 << N) - 17'd1;

   function automatic logic is_bcd(input logic [3:0] d);
      return (d <= 4'd9);
   endfunction

   logic [1:0]   state_q, state_d;
   logic [3:0]   hun_q, hun_d;
   logic [3:0]   ten_q, ten_d;
   logic [3:0]   one_q, one_d;
   logic [9:0]   acc_q, acc_d;
   logic [1:0]   idx_q, idx_d;
   logic [N-1:0] value_q, value_d;
   logic         done_q, done_d;
   logic         edig_q, edig_d;
   logic         eovf_q, eovf_d;

   logic [3:0]   digit_s;
   logic [9:0]   acc_next_s;
   logic [15:0]  acc_ext_s;
   logic         ovf_s;
   logic         digit_bad_s;

   // Datapath: pick the current digit and form the next accumulator value and its range check
   always_comb begin
      case (idx_q)
         2'd0:    digit_s = hun_q;
         2'd1:    digit_s = ten_q;
         2'd2:    digit_s = one_q;
         default: digit_s = 4'd0;
      endcase
      acc_next_s  = (acc_q * 10'd10) + {6'd0, digit_s};
      acc_ext_s   = {6'd0, acc_next_s};
      ovf_s       = ({7'd0, acc_next_s} > MAX_VAL);
      digit_bad_s = !(is_bcd(hun_q) && is_bcd(ten_q) && is_bcd(one_q));
   end

   // Control: IDLE -> CHECK -> ACC x3 -> IDLE, with result and flag updates
   always_comb begin
      state_d = state_q;
      hun_d   = hun_q;
      ten_d   = ten_q;
      one_d   = one_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      value_d = value_q;
      done_d  = 1'b0;
      edig_d  = edig_q;
      eovf_d  = eovf_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               hun_d   = bus.hundreds;
               ten_d   = bus.tens;
               one_d   = bus.ones;
               edig_d  = 1'b0;
               eovf_d  = 1'b0;
               state_d = S_CHECK;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CHECK: begin
            if (digit_bad_s) begin
               edig_d  = 1'b1;
               value_d = {N{1'b0}};
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               acc_d   = 10'd0;
               idx_d   = 2'd0;
               state_d = S_ACC;
            end
         end
         S_ACC: begin
            acc_d = acc_next_s;
            if (idx_q == 2'd2) begin
               if (ovf_s) begin
                  value_d = {N{1'b1}};
                  eovf_d  = 1'b1;
               end else begin
                  value_d = acc_ext_s[N-1:0];
               end
               done_d  = 1'b1;
               idx_d   = 2'd0;
               state_d = S_IDLE;
            end else begin
               idx_d = idx_q + 2'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = 2'd0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         hun_q   <= 4'd0;
         ten_q   <= 4'd0;
         one_q   <= 4'd0;
         acc_q   <= 10'd0;
         idx_q   <= 2'd0;
         value_q <= {N{1'b0}};
         done_q  <= 1'b0;
         edig_q  <= 1'b0;
         eovf_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hun_q   <= hun_d;
         ten_q   <= ten_d;
         one_q   <= one_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         value_q <= value_d;
         done_q  <= done_d;
         edig_q  <= edig_d;
         eovf_q  <= eovf_d;
      end
   end

   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = done_q;
   assign bus.value     = value_q;
   assign bus.err_digit = edig_q;
   assign bus.err_ovf   = eovf_q;
endmodule
